// File: rtl/wb_commit_if.sv
// ---------------------------------------------------------------------------
// wb_commit_if
// Bundles the writeback commit unit's ALU, LSU, issue and register-file
// write signals.
//   slave  modport : used by wb_commit (consumes results, drives rd_* / busy)
//   master modport : used by whoever drives the results (pipeline or bench)
// Signals:
//   i_alu_valid/i_alu_rd/i_alu_data    single-cycle ALU result
//   i_lsu_valid/o_lsu_ready/i_lsu_rd/i_lsu_data  LSU result handshake
//   i_issue_valid/i_issue_rd           long-latency op issue (scoreboard set)
//   o_rd_wren/o_rd_addr/o_rd_data      register file write port
//   o_busy                             pending-LSU-write scoreboard
//   o_fifo_cnt                         LSU result FIFO occupancy
// ---------------------------------------------------------------------------
interface wb_commit_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  logic                     i_alu_valid;
  logic [4:0]               i_alu_rd;
  logic [XLEN-1:0]          i_alu_data;
  logic                     i_lsu_valid;
  logic                     o_lsu_ready;
  logic [4:0]               i_lsu_rd;
  logic [XLEN-1:0]          i_lsu_data;
  logic                     i_issue_valid;
  logic [4:0]               i_issue_rd;
  logic                     o_rd_wren;
  logic [4:0]               o_rd_addr;
  logic [XLEN-1:0]          o_rd_data;
  logic [31:0]              o_busy;
  logic [$clog2(DEPTH):0]   o_fifo_cnt;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  i_issue_valid, i_issue_rd,
    output o_lsu_ready, o_rd_wren, o_rd_addr, o_rd_data, o_busy, o_fifo_cnt
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    output i_issue_valid, i_issue_rd,
    input  o_lsu_ready, o_rd_wren, o_rd_addr, o_rd_data, o_busy, o_fifo_cnt
  );
endinterface

// File: rtl/wb_commit.sv
// ---------------------------------------------------------------------------
// wb_commit
// Writeback commit unit: drives the register file write port with one result
// per cycle. ALU results always win; LSU results queue in a DEPTH-entry FIFO
// and drain when the ALU is idle. A 32-bit scoreboard tracks registers that
// still await an LSU write.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      wb_commit_if.slave (ALU/LSU/issue inputs, rd_* / busy / count)
// Optional feature macro: WB_BYPASS_EN -- when defined, an LSU result that
// arrives with the FIFO empty and the ALU idle goes straight to the output
// register (latency N+1) instead of through the FIFO.
// ---------------------------------------------------------------------------
module wb_commit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  wb_commit_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      fifo_rd_r   [DEPTH];
  logic [XLEN-1:0] fifo_data_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   cnt_r;
  logic            wren_r;
  logic [4:0]      addr_r;
  logic [XLEN-1:0] data_r;
  logic            src_lsu_r;
  logic [31:0]     busy_r;

  logic            ready_s;
  logic            empty_s;
  logic            xfer_s;
  logic            push_s;
  logic            pop_s;
  logic            load_s;
  logic            load_lsu_s;
  logic [4:0]      load_rd_s;
  logic [XLEN-1:0] load_data_s;
  logic [CW-1:0]   cnt_next_s;
  logic [31:0]     busy_next_s;

  // Ready comes from the registered count only, so a full FIFO never accepts
  // even when it pops in the same cycle.
  assign ready_s = (cnt_r != CW'(DEPTH));
  assign empty_s = (cnt_r == {CW{1'b0}});
  assign xfer_s  = bus.i_lsu_valid && ready_s;

  // Commit-slot arbitration: ALU, then FIFO head, then (optionally) bypass.
  always_comb begin
    load_s      = 1'b0;
    load_lsu_s  = 1'b0;
    load_rd_s   = addr_r;
    load_data_s = data_r;
    pop_s       = 1'b0;
    push_s      = xfer_s;
    if (bus.i_alu_valid) begin
      load_s      = 1'b1;
      load_rd_s   = bus.i_alu_rd;
      load_data_s = bus.i_alu_data;
    end else if (!empty_s) begin
      load_s      = 1'b1;
      load_lsu_s  = 1'b1;
      pop_s       = 1'b1;
      load_rd_s   = fifo_rd_r[rd_ptr_r];
      load_data_s = fifo_data_r[rd_ptr_r];
    end else begin
`ifdef WB_BYPASS_EN
      if (xfer_s) begin
        load_s      = 1'b1;
        load_lsu_s  = 1'b1;
        push_s      = 1'b0;
        load_rd_s   = bus.i_lsu_rd;
        load_data_s = bus.i_lsu_data;
      end else begin
        load_s = 1'b0;
      end
`else
      load_s = 1'b0;
`endif
    end
  end

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_next_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_next_s = cnt_r + CW'(1);
      2'b01:   cnt_next_s = cnt_r - CW'(1);
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Scoreboard: clear on the edge the register file captures an LSU write,
  // then apply the issue set so a same-cycle set wins. x0 never goes busy.
  always_comb begin
    busy_next_s = busy_r;
    if (wren_r && src_lsu_r) begin
      busy_next_s[addr_r] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) begin
      busy_next_s[bus.i_issue_rd] = 1'b1;
    end else begin
      busy_next_s[0] = 1'b0;
    end
    busy_next_s[0] = 1'b0;
  end

  // Control state: pointers, count, output register and scoreboard.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      wren_r    <= 1'b0;
      addr_r    <= 5'd0;
      data_r    <= {XLEN{1'b0}};
      src_lsu_r <= 1'b0;
      busy_r    <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      cnt_r     <= cnt_next_s;
      // An rd==0 result still consumes the slot but never raises the enable.
      wren_r    <= load_s && (load_rd_s != 5'd0);
      src_lsu_r <= load_lsu_s;
      if (load_s) begin
        addr_r <= load_rd_s;
        data_r <= load_data_s;
      end
      busy_r    <= busy_next_s;
    end
  end

  // FIFO storage, written at the tail on every accepted push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      fifo_rd_r[wr_ptr_r]   <= bus.i_lsu_rd;
      fifo_data_r[wr_ptr_r] <= bus.i_lsu_data;
    end
  end

  assign bus.o_lsu_ready = ready_s;
  assign bus.o_rd_wren   = wren_r;
  assign bus.o_rd_addr   = addr_r;
  assign bus.o_rd_data   = data_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_fifo_cnt  = cnt_r;
endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
Writeback commit unit. It is the producer side of the register file write port and drives rd address, rd data and rd write-enable. It merges single-cycle ALU results with out-of-order results from the long-latency load/store unit (LSU), buffering LSU results in a small FIFO. It also keeps a busy scoreboard of registers awaiting an LSU result, which decode uses for stall detection.

Parameters:
DEPTH, 4, LSU result FIFO entries; power of two, ≥2
XLEN, 32, data width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_alu_valid  in  1  ALU result valid this cycle; always accepted
i_alu_rd  in  5  ALU destination register
i_alu_data  in  XLEN  ALU result
i_lsu_valid  in  1  LSU result offered
o_lsu_ready  out  1  FIFO can accept an LSU result
i_lsu_rd  in  5  LSU destination register
i_lsu_data  in  XLEN  LSU result
i_issue_valid  in  1  long-latency op issued this cycle
i_issue_rd  in  5  destination of the issued op
o_rd_wren  out  1  register file write enable
o_rd_addr  out  5  register file write address
o_rd_data  out  XLEN  register file write data
o_busy  out  32  scoreboard; bit n=1 means xn has a pending LSU write
o_fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, active-low): o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_busy=0, FIFO empty, o_fifo_cnt=0, pointers 0. Reset mid-operation discards all queued entries and scoreboard state.
- Outputs o_rd_* are registered. Each update is one commit slot per cycle.
- Arbitration at each posedge, in priority order:
  1. i_alu_valid: load the ALU rd/data into the output register. Source flag = ALU.
  2. Otherwise, FIFO non-empty: pop the head into the output register. Source flag = LSU.
  3. Otherwise: o_rd_wren=0. o_rd_addr/o_rd_data hold their previous values.
- rd==0 from either source: the slot is consumed (popped, or ALU cycle used), but o_rd_wren=0 is driven. x0 is never written.
- LSU handshake: a transfer happens when i_lsu_valid && o_lsu_ready at a posedge; the entry is pushed at the tail. o_lsu_ready = (o_fifo_cnt != DEPTH), derived from registered count only.
  - When full, no push occurs even if a pop happens the same cycle.
  - Push and pop in the same cycle on a non-full FIFO: count unchanged.
- Pointers wrap modulo DEPTH.
- Latency:
  - ALU result valid in cycle N: o_rd_wren=1 in cycle N+1. The register file captures it at the end of N+1.
  - LSU accepted in cycle N: earliest o_rd_wren in cycle N+2. It is delayed one extra cycle per intervening ALU valid (ALU starvation of the FIFO is allowed).
- Scoreboard:
  - Set bit i_issue_rd on i_issue_valid when i_issue_rd≠0.
  - Clear bit o_rd_addr at the posedge that ends a cycle where o_rd_wren=1 and source flag = LSU, i.e. the same edge the register file captures the data.
  - Set and clear of the same bit in the same cycle: set wins.
  - o_busy[0] is always 0.
- An ALU write to a register whose busy bit is set does not affect the scoreboard. Ordering is the issuer's responsibility.

Optional Feature:
WB_BYPASS_EN.
- Defined: when the FIFO is empty, i_alu_valid=0 and an LSU transfer occurs, the LSU entry goes directly to the output register without occupying a slot. LSU latency is then N+1; the FIFO count does not change.
- Undefined: every LSU result goes through the FIFO, with minimum latency N+2.

Test Plan:
- Reset, then ALU valid rd=5, data=0xDEADBEEF in cycle 0 -> cycle 1: o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF; cycle 2: o_rd_wren=0.
- ALU rd=0, data=0x1234 -> o_rd_wren stays 0. LSU rd=0 pushed -> popped, o_rd_wren=0, o_fifo_cnt returns to 0.
- Issue rd=7, then LSU rd=7, data=0xA5A5A5A5 with ALU idle -> o_busy[7]=1 until the commit cycle (N+2 without bypass, N+1 with). o_busy[7]=0 the cycle after o_rd_wren=1.
- Hold i_alu_valid=1 for 6 cycles while pushing 4 LSU results (rd=1..4, DEPTH=4) -> o_lsu_ready=0 at count 4, fifth push stalls. After ALU idles, rd 1,2,3,4 commit in order on consecutive cycles.
- Same cycle: issue rd=9 and LSU commit of rd=9 completing -> o_busy[9] remains 1.
- Assert i_rst_n=0 with 3 entries queued and o_busy=0x0000_0086 -> immediately o_fifo_cnt=0, o_busy=0, o_rd_wren=0. No queued entry commits after release.
